// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Receive-side checker for the 8-bit Fibonacci PRBS/scrambler LFSR
// (recurrence s(n) = s(n-8) ^ s(n-6) ^ s(n-5) ^ s(n-3)).
// The checker synchronises itself to the incoming serial stream, flags bit
// errors, and tracks lock and loss of lock.
//
// SEARCH : the history is loaded from received bits. After 8 fill samples,
//          each sample is checked against the bit the recurrence predicts.
//          LOCK_CNT consecutive correct predictions on a non-zero history
//          declare lock.
// LOCKED : the local generator free-runs from its own prediction. Each
//          mismatch pulses err_pulse and bumps err_cnt. LOSS_THRESH errors
//          inside one WINDOW-sample window drop the checker back to SEARCH.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_bit carries a sample this cycle
//   in_bit     received serial bit
//   clr_cnt    synchronous clear of err_cnt (and bit_cnt when enabled)
//   locked     checker is synchronised to the pattern (registered)
//   err_pulse  one-cycle pulse for a mismatch seen while locked (registered)
//   err_cnt    saturating count of locked-state errors (registered)
//   bit_cnt    [PRBS_CHECKER_BITCNT_EN only] saturating count of valid
//              samples taken while locked, for BER = err_cnt / bit_cnt
//
// Optional feature macro: PRBS_CHECKER_BITCNT_EN
// -----------------------------------------------------------------------------
module prbs_checker #(
   parameter int LOCK_CNT    = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHECKER_BITCNT_EN
   ,
   output logic [31:0]      bit_cnt
`endif
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCK   = 1'b1
   } state_t;

   state_t              state;
   logic [7:0]          hist;
   logic [3:0]          fill;
   logic [MATCH_W-1:0]  match;
   logic [WIN_W-1:0]    win_cnt;
   logic [WERR_W-1:0]   win_err;

   logic                pred;
   logic                mismatch;
   logic                lock_err;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // hist[k-1] is the bit from k valid samples ago.
   assign pred     = hist[7] ^ hist[5] ^ hist[4] ^ hist[2];
   assign mismatch = in_bit ^ pred;
   assign lock_err = in_valid && (state == LOCK) && mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SEARCH;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         hist      <= '0;
         fill      <= '0;
         match     <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
      end else begin
         err_pulse <= lock_err;

         // A clear in the same cycle as an error wins: the error is not counted.
         if (clr_cnt)
            err_cnt <= '0;
         else if (lock_err)
            err_cnt <= sat_inc_err(err_cnt);

         if (in_valid) begin
            if (state == SEARCH) begin
               hist <= {hist[6:0], in_bit};
               if (fill != 4'd8) begin
                  fill <= fill + 4'd1;
               end else if (!mismatch && (hist != '0)) begin
                  // An all-zero history predicts zeros forever, so it never
                  // counts towards lock.
                  match <= match + 1'b1;
                  if (match == MATCH_W'(LOCK_CNT - 1)) begin
                     state   <= LOCK;
                     locked  <= 1'b1;
                     win_cnt <= '0;
                     win_err <= '0;
                  end
               end else begin
                  match <= '0;
               end
            end else begin
               // Free-running local generator: received errors never enter
               // the history, so a single flipped bit does not propagate.
               hist <= {hist[6:0], pred};
               if (mismatch && (win_err == WERR_W'(LOSS_THRESH - 1))) begin
                  // Loss of lock takes priority over the end-of-window reset.
                  state   <= SEARCH;
                  locked  <= 1'b0;
                  hist    <= '0;
                  fill    <= '0;
                  match   <= '0;
                  win_cnt <= '0;
                  win_err <= '0;
               end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                  win_cnt <= '0;
                  win_err <= '0;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
                  win_err <= win_err + WERR_W'(mismatch);
               end
            end
         end
      end
   end

`ifdef PRBS_CHECKER_BITCNT_EN
   function automatic logic [31:0] sat_inc_bits(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bit_cnt <= '0;
      else if (clr_cnt)
         bit_cnt <= '0;
      else if (in_valid && (state == LOCK))
         bit_cnt <= sat_inc_bits(bit_cnt);
   end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
//
// Drives the Fibonacci LFSR stream (seed 8'h80) into prbs_checker with
// planted bit errors, gaps and counter clears. Each scenario task pushes
// the expected locked / err_pulse / err_cnt values for every driven cycle
// into a scoreboard queue; a monitor pops one entry per clock edge and
// compares it with the registered outputs. Scenario tasks add inline checks
// at the key sample numbers. The DUT is built with CNT_W=4 so that the
// error counter saturates at 15.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

   localparam int CW = 4;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_bit   = 1'b0;
   logic          clr_cnt  = 1'b0;
   logic          locked;
   logic          err_pulse;
   logic [CW-1:0] err_cnt;
`ifdef PRBS_CHECKER_BITCNT_EN
   logic [31:0]   bit_cnt;
`endif

   always #5 clk = ~clk;

   prbs_checker #(
      .LOCK_CNT   (16),
      .WINDOW     (64),
      .LOSS_THRESH(8),
      .CNT_W      (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .clr_cnt  (clr_cnt),
      .locked   (locked),
      .err_pulse(err_pulse),
      .err_cnt  (err_cnt)
`ifdef PRBS_CHECKER_BITCNT_EN
      ,
      .bit_cnt  (bit_cnt)
`endif
   );

   typedef struct {
      logic          locked;
      logic          pulse;
      logic [CW-1:0] cnt;
      int            id;
   } exp_t;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] gen;

   // Reference Fibonacci LFSR: emits gen[7], feeds back the recurrence.
   task automatic gen_next(output logic b);
      b   = gen[7];
      gen = {gen[6:0], gen[7] ^ gen[5] ^ gen[4] ^ gen[2]};
   endtask

   // Drive one cycle of stimulus and record what the outputs must be after it.
   task automatic step(input logic v, input logic b, input logic c,
                       input logic e_locked, input logic e_pulse,
                       input int e_cnt, input int id);
      exp_t e;
      in_valid = v;
      in_bit   = b;
      clr_cnt  = c;
      e.locked = e_locked;
      e.pulse  = e_pulse;
      e.cnt    = CW'(e_cnt);
      e.id     = id;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: the entry popped at an edge belongs to the sample
   // taken at that edge; outputs are compared 1 ns later.
   always @(posedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         #1;
         n_tests++;
         if ({locked, err_pulse, err_cnt} !== {e.locked, e.pulse, e.cnt}) begin
            n_fail++;
            $display("FAIL sb sample %0d: locked/err_pulse/err_cnt got %0b/%0b/%0d expected %0b/%0b/%0d",
                     e.id, locked, err_pulse, err_cnt, e.locked, e.pulse, e.cnt);
         end
      end
   end

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      clr_cnt  = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
      #2;
      n_tests++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_locked: got %0b expected 0", locked);
      end
      n_tests++;
      if (err_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err_pulse: got %0b expected 0", err_pulse);
      end
      n_tests++;
      if (err_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
      end
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      // Idle cycles with junk data must leave everything at reset values.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0, 0, -1);
   endtask

   task automatic test_clean_lock();
      logic b;
      do_reset();
      gen = 8'h80;
      for (int i = 1; i <= 1000; i++) begin
         gen_next(b);
         step(1'b1, b, 1'b0, i >= 24, 1'b0, 0, i);
         if (i == 23) begin
            n_tests++;
            if (locked !== 1'b0) begin
               n_fail++;
               $display("FAIL clean_lock_s23: locked got %0b expected 0", locked);
            end
         end
         if (i == 24) begin
            n_tests++;
            if (locked !== 1'b1) begin
               n_fail++;
               $display("FAIL clean_lock_s24: locked got %0b expected 1", locked);
            end
         end
      end
`ifdef PRBS_CHECKER_BITCNT_EN
      n_tests++;
      if (bit_cnt !== 32'd976) begin
         n_fail++;
         $display("FAIL clean_bit_cnt: got %0d expected 976", bit_cnt);
      end
`endif
   endtask

   task automatic test_single_error();
      logic b, f;
      int   pulses;
      do_reset();
      gen    = 8'h80;
      pulses = 0;
      for (int i = 1; i <= 120; i++) begin
         gen_next(b);
         f = (i == 100);
         step(1'b1, b ^ f, 1'b0, i >= 24, f, (i >= 100) ? 1 : 0, i);
         if (i > 100 && i <= 108 && err_pulse === 1'b1)
            pulses++;
         if (i == 108) begin
            n_tests++;
            if (pulses != 0 || err_cnt !== CW'(1) || locked !== 1'b1) begin
               n_fail++;
               $display("FAIL single_err_propagation: extra pulses %0d err_cnt %0d locked %0b, required 0/1/1",
                        pulses, err_cnt, locked);
            end
         end
      end
   endtask

   // Eight errors starting at first_err; expected relock 24 samples after
   // the last one.
   task automatic test_loss_of_lock(input int first_err, input int n_samples);
      logic b, f;
      int   last_err, cnt;
      logic exp_l;
      do_reset();
      gen      = 8'h80;
      last_err = first_err + 7;
      for (int i = 1; i <= n_samples; i++) begin
         gen_next(b);
         f     = (i >= first_err && i <= last_err);
         cnt   = (i < first_err) ? 0 : ((i < last_err) ? i - first_err + 1 : 8);
         exp_l = (i >= 24 && i < last_err) || (i >= last_err + 24);
         step(1'b1, b ^ f, 1'b0, exp_l, f, cnt, i);
         if (i == last_err - 1 || i == last_err || i == last_err + 23 || i == last_err + 24) begin
            n_tests++;
            if (locked !== exp_l) begin
               n_fail++;
               $display("FAIL loss_lock sample %0d: locked got %0b expected %0b", i, locked, exp_l);
            end
         end
      end
   endtask

   task automatic test_all_zero();
      do_reset();
      for (int i = 1; i <= 200; i++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, i);
      n_tests++;
      if (locked !== 1'b0 || err_cnt !== '0) begin
         n_fail++;
         $display("FAIL all_zero: locked/err_cnt got %0b/%0d expected 0/0", locked, err_cnt);
      end
   endtask

   task automatic test_gapped_and_clear();
      logic b, f, c;
      int   nv, cnt;
      do_reset();
      gen = 8'h80;
      nv  = 0;
      cnt = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (cyc % 2 == 0) begin
            nv++;
            gen_next(b);
            f = (nv == 30 || nv == 40 || nv == 45);
            c = (nv == 40);
            if (c)
               cnt = 0;
            else if (f)
               cnt++;
            step(1'b1, b ^ f, c, nv >= 24, f, cnt, nv);
            if (nv == 23 || nv == 24) begin
               n_tests++;
               if (locked !== (nv == 24)) begin
                  n_fail++;
                  $display("FAIL gapped_lock valid %0d: locked got %0b expected %0b", nv, locked, nv == 24);
               end
            end
            if (nv == 40) begin
               n_tests++;
               if (err_pulse !== 1'b1 || err_cnt !== '0) begin
                  n_fail++;
                  $display("FAIL clr_vs_err: err_pulse/err_cnt got %0b/%0d expected 1/0", err_pulse, err_cnt);
               end
            end
         end else begin
            step(1'b0, 1'($urandom_range(1, 0)), 1'b0, nv >= 24, 1'b0, cnt, -nv);
         end
      end
   endtask

   task automatic test_saturation();
      logic b, f;
      int   errs;
      do_reset();
      gen  = 8'h80;
      errs = 0;
      for (int i = 1; i <= 360; i++) begin
         gen_next(b);
         f = (i > 24) && ((i - 24) % 16 == 0) && (errs < 20);
         if (f)
            errs++;
         step(1'b1, b ^ f, 1'b0, i >= 24, f, (errs > 15) ? 15 : errs, i);
      end
      n_tests++;
      if (err_cnt !== CW'(15) || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL saturation: err_cnt/locked got %0d/%0b expected 15/1", err_cnt, locked);
      end
   endtask

   // Continues from the locked, saturated state left by test_saturation.
   task automatic test_async_reset();
      logic b;
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      n_tests++;
      if (locked !== 1'b0 || err_cnt !== '0 || err_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: locked/err_cnt/err_pulse got %0b/%0d/%0b expected 0/0/0",
                  locked, err_cnt, err_pulse);
      end
      #2;
      rst = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         gen_next(b);
         step(1'b1, b, 1'b0, i >= 24, 1'b0, 0, i);
         if (i == 23 || i == 24) begin
            n_tests++;
            if (locked !== (i == 24)) begin
               n_fail++;
               $display("FAIL relock_after_rst sample %0d: locked got %0b expected %0b", i, locked, i == 24);
            end
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_clean_lock();
      test_single_error();
      test_loss_of_lock(30, 80);
      test_loss_of_lock(81, 120);
      test_all_zero();
      test_gapped_and_clear();
      test_saturation();
      test_async_reset();
      #5;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
